lm32_tlb_ctrl: RTL and testbench

LM32_TLB_CTRL -- requirements
Module: lm32_tlb_ctrl

---
 rtl/lm32_tlb_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lm32_tlb_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm32_tlb_ctrl.sv
// LM32 TLB maintenance controller: single-entry update/invalidate, full flush, miss latch.
// Optional CFG_TLB_FLUSH_ON_RESET_EN: reset starts a flush of both TLBs instead of idling.
module lm32_tlb_ctrl #(
  parameter int unsigned sets      = 1024,
  parameter int unsigned page_size = 4096,
  localparam int unsigned idx_w    = $clog2(sets),
  localparam int unsigned off_w    = $clog2(page_size),
  localparam int unsigned pfn_w    = 32 - off_w,
  localparam int unsigned tag_w    = pfn_w - idx_w
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_sel,
  input  logic [31:0]      cmd_vaddr,
  input  logic [31:0]      cmd_paddr,
  output logic             itlb_we,
  output logic             dtlb_we,
  output logic [idx_w-1:0] tlb_set,
  output logic             tlb_valid,
  output logic [tag_w-1:0] tlb_tag,
  output logic [pfn_w-1:0] tlb_pfn,
  input  logic             itlb_miss,
  input  logic             dtlb_miss,
  input  logic [31:0]      itlb_miss_addr,
  input  logic [31:0]      dtlb_miss_addr,
  output logic             miss_pending,
  output logic             miss_src,
  output logic [31:0]      miss_addr,
  input  logic             miss_ack,
  output logic             stall_request
);

  typedef enum logic [1:0] {StIdle, StWrite, StFlush} state_e;

  localparam logic [1:0] OpNop    = 2'b00;
  localparam logic [1:0] OpUpdate = 2'b01;
  localparam logic [1:0] OpFlush  = 2'b11;

`ifdef CFG_TLB_FLUSH_ON_RESET_EN
  localparam state_e     StReset   = StFlush;
  localparam logic [1:0] FselReset = 2'b11;
`else
  localparam state_e     StReset   = StIdle;
  localparam logic [1:0] FselReset = 2'b00;
`endif

  state_e           state_q, state_d;
  logic             itlb_we_q, itlb_we_d, dtlb_we_q, dtlb_we_d;
  logic [idx_w-1:0] set_q, set_d;
  logic             valid_q, valid_d;
  logic [tag_w-1:0] tag_q, tag_d;
  logic [pfn_w-1:0] pfn_q, pfn_d;
  logic [1:0]       fsel_q, fsel_d;

  logic unused_offset_bits;
  assign unused_offset_bits = ^{cmd_vaddr[off_w-1:0], cmd_paddr[off_w-1:0]};

  always_comb begin
    state_d   = state_q;
    itlb_we_d = 1'b0;
    dtlb_we_d = 1'b0;
    set_d     = set_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    pfn_d     = pfn_q;
    fsel_d    = fsel_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_op != OpNop && cmd_sel != 2'b00) begin
          itlb_we_d = cmd_sel[0];
          dtlb_we_d = cmd_sel[1];
          if (cmd_op == OpFlush) begin
            state_d = StFlush;
            fsel_d  = cmd_sel;
            set_d   = idx_w'(sets - 1);
            valid_d = 1'b0;
            tag_d   = '0;
            pfn_d   = '0;
          end else begin
            state_d = StWrite;
            set_d   = cmd_vaddr[off_w +: idx_w];
            valid_d = (cmd_op == OpUpdate);
            tag_d   = (cmd_op == OpUpdate) ? cmd_vaddr[31 -: tag_w] : '0;
            pfn_d   = (cmd_op == OpUpdate) ? cmd_paddr[31 -: pfn_w] : '0;
          end
        end
      end
      StWrite: state_d = StIdle;
      StFlush: begin
        // set_q doubles as the flush counter; a post-reset flush starts with no write
        // pending and set_q == 0, so the decrement wraps it to sets-1.
        if ((itlb_we_q || dtlb_we_q) && set_q == '0) begin
          state_d = StIdle;
        end else begin
          itlb_we_d = fsel_q[0];
          dtlb_we_d = fsel_q[1];
          set_d     = set_q - idx_w'(1);
          valid_d   = 1'b0;
          tag_d     = '0;
          pfn_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StReset;
      itlb_we_q <= 1'b0;
      dtlb_we_q <= 1'b0;
      set_q     <= '0;
      valid_q   <= 1'b0;
      tag_q     <= '0;
      pfn_q     <= '0;
      fsel_q    <= FselReset;
    end else begin
      state_q   <= state_d;
      itlb_we_q <= itlb_we_d;
      dtlb_we_q <= dtlb_we_d;
      set_q     <= set_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      pfn_q     <= pfn_d;
      fsel_q    <= fsel_d;
    end
  end

  logic        pend_q, src_q;
  logic [31:0] addr_q;

  // A slot is open when nothing is pending or the record is being acked this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      src_q  <= 1'b0;
      addr_q <= '0;
    end else if (!pend_q || miss_ack) begin
      if (dtlb_miss) begin
        pend_q <= 1'b1;
        src_q  <= 1'b1;
        addr_q <= dtlb_miss_addr;
      end else if (itlb_miss) begin
        pend_q <= 1'b1;
        src_q  <= 1'b0;
        addr_q <= itlb_miss_addr;
      end else begin
        pend_q <= 1'b0;
      end
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign stall_request = (state_q == StFlush);
  assign itlb_we       = itlb_we_q;
  assign dtlb_we       = dtlb_we_q;
  assign tlb_set       = set_q;
  assign tlb_valid     = valid_q;
  assign tlb_tag       = tag_q;
  assign tlb_pfn       = pfn_q;
  assign miss_pending  = pend_q;
  assign miss_src      = src_q;
  assign miss_addr     = addr_q;

endmodule

// File: tb/tb_lm32_tlb_ctrl.sv
// Self-checking bench for lm32_tlb_ctrl (default build, sets=1024, page_size=4096).
module tb_lm32_tlb_ctrl;
  localparam int unsigned Sets = 1024;
  localparam int unsigned Page = 4096;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_sel;
  logic [31:0] cmd_vaddr, cmd_paddr;
  logic        itlb_we, dtlb_we;
  logic [9:0]  tlb_set;
  logic        tlb_valid;
  logic [9:0]  tlb_tag;
  logic [19:0] tlb_pfn;
  logic        itlb_miss, dtlb_miss;
  logic [31:0] itlb_miss_addr, dtlb_miss_addr;
  logic        miss_pending, miss_src;
  logic [31:0] miss_addr;
  logic        miss_ack;
  logic        stall_request;

  int checks = 0;
  int errors = 0;

  // Miss record reference
  bit          m_pend;
  bit          m_src;
  logic [31:0] m_addr;

  lm32_tlb_ctrl #(.sets(Sets), .page_size(Page)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
    .cmd_vaddr(cmd_vaddr), .cmd_paddr(cmd_paddr),
    .itlb_we(itlb_we), .dtlb_we(dtlb_we), .tlb_set(tlb_set), .tlb_valid(tlb_valid),
    .tlb_tag(tlb_tag), .tlb_pfn(tlb_pfn),
    .itlb_miss(itlb_miss), .dtlb_miss(dtlb_miss),
    .itlb_miss_addr(itlb_miss_addr), .dtlb_miss_addr(dtlb_miss_addr),
    .miss_pending(miss_pending), .miss_src(miss_src), .miss_addr(miss_addr),
    .miss_ack(miss_ack), .stall_request(stall_request)
  );

  always #5 clk_i = ~clk_i;

  // Advance the miss reference with the inputs about to be sampled, then one clock.
  task automatic tick();
    if (rst_i) begin
      m_pend = 0; m_src = 0; m_addr = '0;
    end else if (!m_pend || miss_ack) begin
      if (dtlb_miss) begin
        m_pend = 1; m_src = 1; m_addr = dtlb_miss_addr;
      end else if (itlb_miss) begin
        m_pend = 1; m_src = 0; m_addr = itlb_miss_addr;
      end else begin
        m_pend = 0;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1;
    tick();
    tick();
    checks++;
    if ({itlb_we, dtlb_we} !== 2'b00) begin
      errors++; $display("FAIL reset_we: got %b want 00", {itlb_we, dtlb_we});
    end
    checks++;
    if ({tlb_set, tlb_valid, tlb_tag, tlb_pfn} !== 41'd0) begin
      errors++;
      $display("FAIL reset_data: got set=%h v=%b tag=%h pfn=%h want all 0",
               tlb_set, tlb_valid, tlb_tag, tlb_pfn);
    end
    checks++;
    if ({miss_pending, miss_src, miss_addr} !== 34'd0) begin
      errors++;
      $display("FAIL reset_miss: got p=%b s=%b a=%h want 0", miss_pending, miss_src, miss_addr);
    end
    rst_i = 0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || stall_request !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b stall=%b want 1/0", cmd_ready, stall_request);
    end
  endtask

  task automatic test_update_directed();
    cmd_valid = 1; cmd_op = 2'b01; cmd_sel = 2'b10;
    cmd_vaddr = 32'h1234_5000; cmd_paddr = 32'hABCD_E000;
    tick();
    cmd_valid = 0; cmd_op = 2'b00;
    checks++;
    if ({itlb_we, dtlb_we} !== 2'b01 || tlb_set !== 10'h345 || tlb_tag !== 10'h048 ||
        tlb_pfn !== 20'hABCDE || tlb_valid !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL update_dir: got iwe=%b dwe=%b set=%h tag=%h pfn=%h v=%b rdy=%b want 0 1 345 048 abcde 1 0",
               itlb_we, dtlb_we, tlb_set, tlb_tag, tlb_pfn, tlb_valid, cmd_ready);
    end
    tick();
    checks++;
    if ({itlb_we, dtlb_we} !== 2'b00 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL update_dir_end: got we=%b rdy=%b want 00/1", {itlb_we, dtlb_we}, cmd_ready);
    end
  endtask

  task automatic test_random_cmds();
    logic [31:0] va, pa;
    logic [1:0]  op, sel;
    bit          vld, wr;
    for (int n = 0; n < 60; n++) begin
      va  = $urandom; pa = $urandom;
      op  = 2'($urandom_range(0, 2));
      sel = 2'($urandom_range(0, 3));
      vld = ($urandom_range(0, 4) != 0);
      wr  = vld && op != 2'b00 && sel != 2'b00;
      cmd_valid = vld; cmd_op = op; cmd_sel = sel; cmd_vaddr = va; cmd_paddr = pa;
      tick();
      cmd_valid = 0;
      checks++;
      if ({itlb_we, dtlb_we} !== (wr ? {sel[0], sel[1]} : 2'b00) || cmd_ready !== !wr) begin
        errors++;
        $display("FAIL rand_cmd_we[%0d]: got we=%b rdy=%b want we=%b rdy=%b", n,
                 {itlb_we, dtlb_we}, cmd_ready, wr ? {sel[0], sel[1]} : 2'b00, !wr);
      end
      if (wr) begin
        checks++;
        if (tlb_set !== 10'((va / Page) % Sets) || tlb_valid !== (op == 2'b01) ||
            tlb_tag !== ((op == 2'b01) ? 10'(va / (Page * Sets)) : 10'd0) ||
            tlb_pfn !== ((op == 2'b01) ? 20'(pa / Page) : 20'd0)) begin
          errors++;
          $display("FAIL rand_cmd_data[%0d]: got set=%h v=%b tag=%h pfn=%h for op=%b va=%h pa=%h",
                   n, tlb_set, tlb_valid, tlb_tag, tlb_pfn, op, va, pa);
        end
        tick();
        checks++;
        if ({itlb_we, dtlb_we} !== 2'b00 || cmd_ready !== 1'b1) begin
          errors++;
          $display("FAIL rand_cmd_end[%0d]: got we=%b rdy=%b want 00/1", n,
                   {itlb_we, dtlb_we}, cmd_ready);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [1:0] sel;
    sel = 2'($urandom_range(1, 3));
    cmd_valid = 1; cmd_op = 2'b11; cmd_sel = sel;
    tick();
    cmd_valid = 0; cmd_op = 2'b00;
    for (int i = 0; i < int'(Sets); i++) begin
      checks++;
      if ({itlb_we, dtlb_we} !== {sel[0], sel[1]} || tlb_set !== 10'(Sets - 1 - i) ||
          tlb_valid !== 1'b0 || tlb_tag !== 10'd0 || tlb_pfn !== 20'd0 ||
          stall_request !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL flush[%0d]: got we=%b set=%0d v=%b stall=%b rdy=%b want we=%b set=%0d",
                 i, {itlb_we, dtlb_we}, tlb_set, tlb_valid, stall_request, cmd_ready,
                 {sel[0], sel[1]}, Sets - 1 - i);
      end
      // Miss traffic runs concurrently with the flush
      itlb_miss = ($urandom_range(0, 3) == 0); itlb_miss_addr = $urandom;
      dtlb_miss = ($urandom_range(0, 3) == 0); dtlb_miss_addr = $urandom;
      miss_ack  = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (miss_pending !== m_pend || (m_pend && {miss_src, miss_addr} !== {m_src, m_addr})) begin
        errors++;
        $display("FAIL flush_miss[%0d]: got p=%b s=%b a=%h want p=%b s=%b a=%h", i,
                 miss_pending, miss_src, miss_addr, m_pend, m_src, m_addr);
      end
    end
    itlb_miss = 0; dtlb_miss = 0; miss_ack = 0;
    checks++;
    if ({itlb_we, dtlb_we} !== 2'b00 || stall_request !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_end: got we=%b stall=%b rdy=%b want 00/0/1",
               {itlb_we, dtlb_we}, stall_request, cmd_ready);
    end
  endtask

  task automatic test_miss_directed();
    miss_ack = 1;
    tick();
    miss_ack = 0;
    itlb_miss = 1; itlb_miss_addr = 32'h1000; dtlb_miss = 1; dtlb_miss_addr = 32'h2000;
    tick();
    itlb_miss = 1; itlb_miss_addr = 32'h5000; dtlb_miss = 0;
    checks++;
    if ({miss_pending, miss_src, miss_addr} !== {1'b1, 1'b1, 32'h2000}) begin
      errors++;
      $display("FAIL miss_both: got p=%b s=%b a=%h want 1 1 00002000",
               miss_pending, miss_src, miss_addr);
    end
    tick();
    itlb_miss = 0;
    checks++;
    if ({miss_pending, miss_src, miss_addr} !== {1'b1, 1'b1, 32'h2000}) begin
      errors++;
      $display("FAIL miss_ignored: got p=%b s=%b a=%h want 1 1 00002000",
               miss_pending, miss_src, miss_addr);
    end
    miss_ack = 1; dtlb_miss = 1; dtlb_miss_addr = 32'h3000;
    tick();
    dtlb_miss = 0;
    checks++;
    if ({miss_pending, miss_addr} !== {1'b1, 32'h3000}) begin
      errors++;
      $display("FAIL miss_ack_new: got p=%b a=%h want 1 00003000", miss_pending, miss_addr);
    end
    tick();
    miss_ack = 0;
    checks++;
    if (miss_pending !== 1'b0) begin
      errors++; $display("FAIL miss_clear: got p=%b want 0", miss_pending);
    end
  endtask

  task automatic test_miss_random();
    for (int n = 0; n < 80; n++) begin
      itlb_miss = ($urandom_range(0, 2) == 0); itlb_miss_addr = $urandom;
      dtlb_miss = ($urandom_range(0, 2) == 0); dtlb_miss_addr = $urandom;
      miss_ack  = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (miss_pending !== m_pend || (m_pend && {miss_src, miss_addr} !== {m_src, m_addr})) begin
        errors++;
        $display("FAIL miss_rand[%0d]: got p=%b s=%b a=%h want p=%b s=%b a=%h", n,
                 miss_pending, miss_src, miss_addr, m_pend, m_src, m_addr);
      end
    end
    itlb_miss = 0; dtlb_miss = 0; miss_ack = 0;
  endtask

  task automatic test_held_during_flush();
    int n_flush, n_inv, inv_cyc;
    logic [31:0] va;
    n_flush = 0; n_inv = 0; inv_cyc = 0;
    va = $urandom;
    cmd_valid = 1; cmd_op = 2'b11; cmd_sel = 2'b01;
    tick();
    cmd_op = 2'b10; cmd_sel = 2'b10; cmd_vaddr = va; cmd_paddr = $urandom;
    for (int c = 1; c <= 1100; c++) begin
      if (itlb_we) n_flush++;
      if (dtlb_we) begin
        n_inv++;
        inv_cyc = c;
        cmd_valid = 0;
        checks++;
        if (tlb_set !== 10'((va / Page) % Sets) || tlb_valid !== 1'b0 ||
            tlb_tag !== 10'd0 || tlb_pfn !== 20'd0) begin
          errors++;
          $display("FAIL held_inv_data: got set=%h v=%b tag=%h pfn=%h want set=%h 0 0 0",
                   tlb_set, tlb_valid, tlb_tag, tlb_pfn, 10'((va / Page) % Sets));
        end
      end
      tick();
    end
    cmd_valid = 0; cmd_op = 2'b00;
    checks++;
    if (n_flush != int'(Sets) || n_inv != 1 || inv_cyc != int'(Sets) + 2) begin
      errors++;
      $display("FAIL held_cmd: got flush_writes=%0d inv_writes=%0d inv_cycle=%0d want %0d 1 %0d",
               n_flush, n_inv, inv_cyc, Sets, Sets + 2);
    end
  endtask

  task automatic test_reset_mid_flush();
    bit hit;
    hit = 0;
    cmd_valid = 1; cmd_op = 2'b11; cmd_sel = 2'b11;
    tick();
    cmd_valid = 0; cmd_op = 2'b00;
    for (int c = 0; c < 1100 && !hit; c++) begin
      if (tlb_set == 10'd500 && dtlb_we) hit = 1;
      else tick();
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL rst_flush_reach: got no write to set 500 want one");
    end
    rst_i = 1;
    tick();
    checks++;
    if ({itlb_we, dtlb_we} !== 2'b00 || tlb_set !== 10'd0 || tlb_valid !== 1'b0 ||
        miss_pending !== 1'b0) begin
      errors++;
      $display("FAIL rst_flush_abort: got we=%b set=%h v=%b p=%b want 00 0 0 0",
               {itlb_we, dtlb_we}, tlb_set, tlb_valid, miss_pending);
    end
    rst_i = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({itlb_we, dtlb_we} !== 2'b00 || cmd_ready !== 1'b1 || stall_request !== 1'b0) begin
        errors++;
        $display("FAIL rst_flush_idle[%0d]: got we=%b rdy=%b stall=%b want 00 1 0", c,
                 {itlb_we, dtlb_we}, cmd_ready, stall_request);
      end
    end
  endtask

  initial begin
    rst_i = 1; cmd_valid = 0; cmd_op = 0; cmd_sel = 0; cmd_vaddr = 0; cmd_paddr = 0;
    itlb_miss = 0; dtlb_miss = 0; itlb_miss_addr = 0; dtlb_miss_addr = 0; miss_ack = 0;
    m_pend = 0; m_src = 0; m_addr = '0;
    test_reset();
    test_update_directed();
    test_random_cmds();
    test_flush();
    test_miss_directed();
    test_miss_random();
    test_held_during_flush();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
